cp0_param: RTL and testbench
============================

CP0_PARAM -- requirements
Module: cp0_param

Interface
REQ-001 Parameter NUM_EXT_INT, default 6, number of external interrupt lines mapped to Cause.IP[2 +: NUM_EXT_INT], legal range 1..6.
REQ-002 Parameter COUNT_DIV, default 2, clock cycles per Count increment, legal range 1..16.
REQ-003 Parameter PRID, default 32'h0000_4220, read-only value of register 15.
REQ-004 Parameter TIMER_IP, default 7, Cause.IP bit ORed with the timer interrupt, legal range 2..7.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 resetn  in  1  asynchronous, active-low reset.
REQ-007 wr_en / wr_idx / wr_data  in  1/5/32  MTC0 write strobe, register index, data.
REQ-008 rd_idx  in  5  MFC0 index; rd_data  out  32  combinational read data.
REQ-009 exc_valid / exc_code / exc_pc / exc_bd  in  1/5/32/1  exception commit, ExcCode, faulting PC, in-delay-slot flag.
REQ-010 exc_badaddr_valid / exc_badaddr  in  1/32  BadVAddr update enable and value, honoured only with exc_valid.
REQ-011 eret  in  1  ERET commit.
REQ-012 ext_int  in  NUM_EXT_INT  level-sensitive external interrupt lines.
REQ-013 epc  out  32  current EPC; status_exl  out  1  current Status.EXL.
REQ-014 int_pending  out  8  (Cause.IP & Status.IM); int_req  out  1  interrupt request to the pipeline.

Function
REQ-015 Registers: BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13), EPC(14), PRId(15); other indices read 0, writes ignored.
REQ-016 Status read = {9'b0, BEV=1, 6'b0, IM[7:0], 6'b0, EXL, IE}; writable bits IM, EXL, IE only.
REQ-017 Cause read = {BD, 1'b0, TI, 13'b0, IP[7:0], 1'b0, ExcCode[4:0], 2'b00}; only IP[1:0] writable.
REQ-018 Per-cycle priority: eret > exc_valid > wr_en; lower-priority inputs in the same cycle are discarded.
REQ-019 eret: EXL <= 0 next cycle; no other register changes.
REQ-020 exc_valid: ExcCode <= exc_code; BadVAddr <= exc_badaddr if exc_badaddr_valid; if EXL==0 then EPC <= exc_bd ? exc_pc-4 : exc_pc (mod 2^32), BD <= exc_bd, EXL <= 1; if EXL==1, EPC and BD unchanged.
REQ-021 Divider counter 0..COUNT_DIV-1 increments every cycle; on wrap Count <= Count+1 (wraps 32'hFFFF_FFFF -> 0); COUNT_DIV==1 increments every cycle.
REQ-022 Write to Count loads wr_data and clears the divider; the write wins over a same-cycle increment.
REQ-023 TI sets in the cycle Count is incremented to a value equal to Compare; TI remains set until a write to Compare.
REQ-024 Write to Compare loads wr_data and clears TI, overriding a same-cycle match set.
REQ-025 ext_int passes through a 2-flop synchroniser; IP[2 +: NUM_EXT_INT] = synchronised lines, IP[TIMER_IP] additionally ORed with TI, unused IP[7:2] bits 0.
REQ-026 int_req = |int_pending & IE & ~EXL, combinational from registered state only.
REQ-027 rd_data reflects register state before the current edge (no write bypass).
REQ-028 epc and status_exl are direct register outputs.

Reset
REQ-029 On resetn low, asynchronously: BadVAddr, Count, Compare, EPC, divider, TI, synchronisers = 0; Status = 32'h0040_0000 (IE=0, EXL=0, IM=0); Cause = 0; int_req = 0.
REQ-030 Reset asserted mid-exception or mid-write discards that update; first update follows the first rising edge after resetn deasserts.

Verification
REQ-031 Reset, COUNT_DIV=2 -> Count reads 0,0,1,1,2 over consecutive cycles; Status reads 32'h0040_0000.
REQ-032 Write Compare=5, Status=32'h0000_8001 -> TI and int_req rise the cycle Count becomes 5; write Compare=100 -> TI and int_req clear next cycle.
REQ-033 EXL=0, exception exc_pc=32'hBFC0_0104, exc_bd=1, code 4, badaddr 32'h1 -> EPC=32'hBFC0_0100, BD=1, EXL=1, ExcCode=4, BadVAddr=1; second exception code 8 -> EPC unchanged, ExcCode=8.
REQ-034 eret with same-cycle wr_en to EPC -> EXL=0, EPC unchanged.
REQ-035 ext_int[0]=1 with IM[2]=1, IE=1 -> int_pending[2] and int_req assert exactly 2 cycles later; EXL=1 masks int_req.
REQ-036 Count=32'hFFFF_FFFF, Compare=0 -> Count wraps to 0 and TI sets; same-cycle Count write of 7 -> Count=7, no TI.

Source files
------------

// File: rtl/cp0_param.sv
// MIPS-style coprocessor 0 subset: exception state, Count/Compare timer and interrupt
// aggregation, with MTC0 writes and combinational MFC0 reads.
module cp0_param #(
  parameter int unsigned NUM_EXT_INT = 6,
  parameter int unsigned COUNT_DIV   = 2,
  parameter logic [31:0] PRID        = 32'h0000_4220,
  parameter int unsigned TIMER_IP    = 7
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   wr_en,
  input  logic [4:0]             wr_idx,
  input  logic [31:0]            wr_data,
  input  logic [4:0]             rd_idx,
  output logic [31:0]            rd_data,
  input  logic                   exc_valid,
  input  logic [4:0]             exc_code,
  input  logic [31:0]            exc_pc,
  input  logic                   exc_bd,
  input  logic                   exc_badaddr_valid,
  input  logic [31:0]            exc_badaddr,
  input  logic                   eret,
  input  logic [NUM_EXT_INT-1:0] ext_int,
  output logic [31:0]            epc,
  output logic                   status_exl,
  output logic [7:0]             int_pending,
  output logic                   int_req
);

  localparam int unsigned     DIV_W     = 4;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);
  localparam logic [2:0]      TIMER_BIT = 3'(TIMER_IP);

  localparam logic [4:0] IDX_BADVADDR = 5'd8;
  localparam logic [4:0] IDX_COUNT    = 5'd9;
  localparam logic [4:0] IDX_COMPARE  = 5'd11;
  localparam logic [4:0] IDX_STATUS   = 5'd12;
  localparam logic [4:0] IDX_CAUSE    = 5'd13;
  localparam logic [4:0] IDX_EPC      = 5'd14;
  localparam logic [4:0] IDX_PRID     = 5'd15;

  logic [31:0]            badvaddr_q, badvaddr_d;
  logic [31:0]            count_q, count_d;
  logic [31:0]            compare_q, compare_d;
  logic [31:0]            epc_q, epc_d;
  logic [7:0]             im_q, im_d;
  logic                   exl_q, exl_d;
  logic                   ie_q, ie_d;
  logic                   bd_q, bd_d;
  logic                   ti_q, ti_d;
  logic [4:0]             exccode_q, exccode_d;
  logic [1:0]             ip_sw_q, ip_sw_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic [NUM_EXT_INT-1:0] sync1_q, sync2_q;

  logic                   tick_c;
  logic [7:0]             ip_c;
  logic [31:0]            status_c, cause_c;

  // Interrupt pending vector: software bits, synchronised lines, timer on its chosen bit.
  always_comb begin
    ip_c                   = {6'b0, ip_sw_q};
    ip_c[2 +: NUM_EXT_INT] = sync2_q;
    ip_c[TIMER_BIT]        = ip_c[TIMER_BIT] | ti_q;
  end

  assign status_c = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
  assign cause_c  = {bd_q, 1'b0, ti_q, 13'b0, ip_c, 1'b0, exccode_q, 2'b00};

  assign int_pending = ip_c & im_q;
  assign int_req     = (|int_pending) & ie_q & ~exl_q;
  assign epc         = epc_q;
  assign status_exl  = exl_q;
  assign tick_c      = (div_q == DIV_LAST);

  always_comb begin
    case (rd_idx)
      IDX_BADVADDR: rd_data = badvaddr_q;
      IDX_COUNT:    rd_data = count_q;
      IDX_COMPARE:  rd_data = compare_q;
      IDX_STATUS:   rd_data = status_c;
      IDX_CAUSE:    rd_data = cause_c;
      IDX_EPC:      rd_data = epc_q;
      IDX_PRID:     rd_data = PRID;
      default:      rd_data = 32'h0;
    endcase
  end

  // Next state: free-running timer first, then eret > exception > MTC0.
  always_comb begin
    badvaddr_d = badvaddr_q;
    count_d    = count_q;
    compare_d  = compare_q;
    epc_d      = epc_q;
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ti_d       = ti_q;
    exccode_d  = exccode_q;
    ip_sw_d    = ip_sw_q;
    div_d      = tick_c ? '0 : div_q + DIV_W'(1);

    if (tick_c) begin
      count_d = count_q + 32'd1;
      if ((count_q + 32'd1) == compare_q) ti_d = 1'b1;
    end

    if (eret) begin
      exl_d = 1'b0;
    end else if (exc_valid) begin
      exccode_d = exc_code;
      if (exc_badaddr_valid) badvaddr_d = exc_badaddr;
      if (!exl_q) begin
        epc_d = exc_bd ? (exc_pc - 32'd4) : exc_pc;
        bd_d  = exc_bd;
        exl_d = 1'b1;
      end
    end else if (wr_en) begin
      case (wr_idx)
        IDX_COUNT: begin
          count_d = wr_data;
          div_d   = '0;
          ti_d    = ti_q;
        end
        IDX_COMPARE: begin
          compare_d = wr_data;
          ti_d      = 1'b0;
        end
        IDX_STATUS: begin
          im_d  = wr_data[15:8];
          exl_d = wr_data[1];
          ie_d  = wr_data[0];
        end
        IDX_CAUSE: ip_sw_d = wr_data[9:8];
        IDX_EPC:   epc_d   = wr_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      badvaddr_q <= '0;
      count_q    <= '0;
      compare_q  <= '0;
      epc_q      <= '0;
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ti_q       <= 1'b0;
      exccode_q  <= '0;
      ip_sw_q    <= '0;
      div_q      <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
    end else begin
      badvaddr_q <= badvaddr_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      epc_q      <= epc_d;
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ti_q       <= ti_d;
      exccode_q  <= exccode_d;
      ip_sw_q    <= ip_sw_d;
      div_q      <= div_d;
      sync1_q    <= ext_int;
      sync2_q    <= sync1_q;
    end
  end

endmodule

// File: tb/tb_cp0_param.sv
// Directed bench for cp0_param with default parameters; expected values are hand-derived.
module tb_cp0_param;

  logic        clk = 1'b0;
  logic        resetn;
  logic        wr_en;
  logic [4:0]  wr_idx;
  logic [31:0] wr_data;
  logic [4:0]  rd_idx;
  logic [31:0] rd_data;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic        exc_badaddr_valid;
  logic [31:0] exc_badaddr;
  logic        eret;
  logic [5:0]  ext_int;
  logic [31:0] epc;
  logic        status_exl;
  logic [7:0]  int_pending;
  logic        int_req;

  int checks = 0;
  int errors = 0;
  logic [31:0] r;

  cp0_param dut (
    .clk(clk), .resetn(resetn),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .rd_idx(rd_idx), .rd_data(rd_data),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc), .exc_bd(exc_bd),
    .exc_badaddr_valid(exc_badaddr_valid), .exc_badaddr(exc_badaddr),
    .eret(eret), .ext_int(ext_int),
    .epc(epc), .status_exl(status_exl), .int_pending(int_pending), .int_req(int_req)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] idx, output logic [31:0] d);
    rd_idx = idx;
    #1;
    d = rd_data;
  endtask

  task automatic wr(input logic [4:0] idx, input logic [31:0] d);
    wr_en = 1'b1; wr_idx = idx; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; wr_en = 1'b0; wr_idx = '0; wr_data = '0; rd_idx = '0;
    exc_valid = 1'b0; exc_code = '0; exc_pc = '0; exc_bd = 1'b0;
    exc_badaddr_valid = 1'b0; exc_badaddr = '0; eret = 1'b0; ext_int = '0;

    repeat (2) tick();
    rd(5'd12, r);  check("rst_status", r, 32'h0040_0000);
    rd(5'd13, r);  check("rst_cause", r, 32'h0);
    check("rst_int_req", 32'(int_req), 32'h0);
    check("rst_epc", epc, 32'h0);
    resetn = 1'b1;

    // Count with divide-by-two: 0,0,1,1,2
    rd(5'd9, r);  check("count_c0", r, 32'd0);
    tick(); rd(5'd9, r);  check("count_c1", r, 32'd0);
    tick(); rd(5'd9, r);  check("count_c2", r, 32'd1);
    tick(); rd(5'd9, r);  check("count_c3", r, 32'd1);
    tick(); rd(5'd9, r);  check("count_c4", r, 32'd2);
    rd(5'd15, r); check("prid", r, 32'h0000_4220);
    rd(5'd3, r);  check("unmapped", r, 32'h0);

    // Timer interrupt on Count==Compare
    wr(5'd11, 32'd5);
    wr(5'd12, 32'h0000_8001);
    rd(5'd12, r); check("status_wr", r, 32'h0040_8001);
    tick(); tick(); tick();
    rd(5'd9, r);  check("count_pre5", r, 32'd4);
    check("int_req_pre5", 32'(int_req), 32'h0);
    tick();
    rd(5'd9, r);  check("count_eq5", r, 32'd5);
    rd(5'd13, r); check("ti_set", r & 32'h2000_0000, 32'h2000_0000);
    check("int_req_ti", 32'(int_req), 32'h1);
    check("pending_ti", 32'(int_pending), 32'h80);
    wr(5'd11, 32'd100);
    rd(5'd13, r); check("ti_clr", r & 32'h2000_0000, 32'h0);
    check("int_req_clr", 32'(int_req), 32'h0);

    // Exception in delay slot, then nested exception with discarded MTC0
    exc_valid = 1'b1; exc_code = 5'd4; exc_pc = 32'hBFC0_0104; exc_bd = 1'b1;
    exc_badaddr_valid = 1'b1; exc_badaddr = 32'h1;
    tick();
    check("exc1_epc", epc, 32'hBFC0_0100);
    check("exc1_exl", 32'(status_exl), 32'h1);
    rd(5'd13, r); check("exc1_cause", r, 32'h8000_0010);
    rd(5'd8, r);  check("exc1_badvaddr", r, 32'h1);
    exc_code = 5'd8; exc_pc = 32'h0000_1234; exc_bd = 1'b0; exc_badaddr_valid = 1'b0;
    wr_en = 1'b1; wr_idx = 5'd14; wr_data = 32'hDEAD_BEEF;
    tick();
    exc_valid = 1'b0; wr_en = 1'b0;
    check("exc2_epc", epc, 32'hBFC0_0100);
    rd(5'd13, r); check("exc2_cause", r, 32'h8000_0020);
    rd(5'd8, r);  check("exc2_badvaddr", r, 32'h1);

    // ERET beats same-cycle EPC write
    eret = 1'b1; wr_en = 1'b1; wr_idx = 5'd14; wr_data = 32'h0000_CAFE;
    tick();
    eret = 1'b0; wr_en = 1'b0;
    check("eret_exl", 32'(status_exl), 32'h0);
    check("eret_epc", epc, 32'hBFC0_0100);

    // External interrupt through the synchroniser, then EXL masking
    wr(5'd12, 32'h0000_0401);
    ext_int = 6'b000001;
    tick();
    check("ext_pend_1", 32'(int_pending), 32'h0);
    check("ext_req_1", 32'(int_req), 32'h0);
    tick();
    check("ext_pend_2", 32'(int_pending), 32'h04);
    check("ext_req_2", 32'(int_req), 32'h1);
    wr(5'd12, 32'h0000_0403);
    check("exl_mask_req", 32'(int_req), 32'h0);
    check("exl_mask_pend", 32'(int_pending), 32'h04);
    ext_int = '0;
    tick(); tick();

    // Count wrap matches Compare=0
    wr(5'd9, 32'hFFFF_FFFF);
    wr(5'd11, 32'd0);
    rd(5'd13, r); check("wrap_ti_pre", r & 32'h2000_0000, 32'h0);
    tick();
    rd(5'd9, r);  check("wrap_count", r, 32'd0);
    rd(5'd13, r); check("wrap_ti", r & 32'h2000_0000, 32'h2000_0000);

    // Count write at the would-be wrap cycle suppresses the match
    wr(5'd9, 32'hFFFF_FFFF);
    wr(5'd11, 32'd0);
    rd(5'd13, r); check("wr_ti_pre", r & 32'h2000_0000, 32'h0);
    wr(5'd9, 32'd7);
    rd(5'd9, r);  check("wr_count", r, 32'd7);
    rd(5'd13, r); check("wr_no_ti", r & 32'h2000_0000, 32'h0);

    // Asynchronous reset mid-write discards it
    wr_en = 1'b1; wr_idx = 5'd14; wr_data = 32'h1111_2222;
    #2 resetn = 1'b0;
    #1;
    check("arst_epc", epc, 32'h0);
    rd(5'd12, r); check("arst_status", r, 32'h0040_0000);
    tick();
    check("arst_hold_epc", epc, 32'h0);
    wr_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
